// File: rtl/lsu_gpr_writeback.sv
// LSU read-return writeback sequencer.
// Collects 32-bit memory response beats for an issued load and packs them
// into SGPR (4 dwords) or VGPR (64 lanes) register-file writes, one write
// per pass, with a done pulse on the final write.
module lsu_gpr_writeback #(
    parameter int WFID_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_start,
    input  logic [WFID_WIDTH-1:0] wb_wfid,
    input  logic                  wb_mem_gpr,
    input  logic [8:0]            wb_sgpr_base,
    input  logic [9:0]            wb_vgpr_base,
    input  logic [1:0]            wb_gpr_op_depth,
    input  logic [3:0]            wb_sgpr_wr_mask,
    input  logic [63:0]           wb_exec_mask,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    output logic                  busy,
    output logic                  sgpr_wr_en,
    output logic [8:0]            sgpr_wr_addr,
    output logic [127:0]          sgpr_wr_data,
    output logic [3:0]            sgpr_wr_mask,
    output logic                  vgpr_wr_en,
    output logic [9:0]            vgpr_wr_addr,
    output logic [2047:0]         vgpr_wr_data,
    output logic [63:0]           vgpr_wr_mask,
    output logic                  wb_done,
    output logic [WFID_WIDTH-1:0] wb_done_wfid
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WFID_WIDTH-1:0] lat_wfid;
    logic                  lat_mem_gpr;
    logic [8:0]            lat_sgpr_base;
    logic [9:0]            lat_vgpr_base;
    logic [1:0]            lat_depth;
    logic [3:0]            lat_sgpr_mask;
    logic [63:0]           lat_exec_mask;

    logic [5:0]    beat_cnt;
    logic [1:0]    pass_cnt;
    logic [2047:0] acc;
    logic [2047:0] acc_merged;
    logic [5:0]    last_idx;
    logic          accept;
    logic          pass_end;
    logic          op_end;

    assign busy     = (state == COLLECT);
    assign accept   = (state == COLLECT) && mem_rsp_valid;
    assign pass_end = accept && (beat_cnt == last_idx);
    assign op_end   = pass_end && (pass_cnt == lat_depth);

    // Index of the last beat in a pass: all 64 lanes for VGPR, mask-derived for SGPR.
    always_comb begin
        last_idx = 6'd3;
        if (lat_mem_gpr) begin
            last_idx = 6'd63;
        end else if (lat_sgpr_mask == 4'b0001) begin
            last_idx = 6'd0;
        end else if (lat_sgpr_mask == 4'b0011) begin
            last_idx = 6'd1;
        end
    end

    // Accumulator with the current beat dropped into its dword/lane slot.
    always_comb begin
        acc_merged = acc;
        acc_merged[{beat_cnt, 5'b00000} +: 32] = mem_rsp_data;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: launch from IDLE, return after the last beat of the final pass.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wb_start) state_next = COLLECT;
            COLLECT: if (op_end)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation latch, beat collection and registered write/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_wfid      <= '0;
            lat_mem_gpr   <= 1'b0;
            lat_sgpr_base <= '0;
            lat_vgpr_base <= '0;
            lat_depth     <= '0;
            lat_sgpr_mask <= '0;
            lat_exec_mask <= '0;
            beat_cnt      <= '0;
            pass_cnt      <= '0;
            acc           <= '0;
            sgpr_wr_en    <= 1'b0;
            sgpr_wr_addr  <= '0;
            sgpr_wr_data  <= '0;
            sgpr_wr_mask  <= '0;
            vgpr_wr_en    <= 1'b0;
            vgpr_wr_addr  <= '0;
            vgpr_wr_data  <= '0;
            vgpr_wr_mask  <= '0;
            wb_done       <= 1'b0;
            wb_done_wfid  <= '0;
        end else begin
            sgpr_wr_en <= 1'b0;
            vgpr_wr_en <= 1'b0;
            wb_done    <= 1'b0;
            if ((state == IDLE) && wb_start) begin
                lat_wfid      <= wb_wfid;
                lat_mem_gpr   <= wb_mem_gpr;
                lat_sgpr_base <= wb_sgpr_base;
                lat_vgpr_base <= wb_vgpr_base;
                lat_depth     <= wb_gpr_op_depth;
                lat_sgpr_mask <= wb_sgpr_wr_mask;
                lat_exec_mask <= wb_exec_mask;
                beat_cnt      <= '0;
                pass_cnt      <= '0;
                acc           <= '0;
            end else if (accept) begin
                if (pass_end) begin
                    acc      <= '0;
                    beat_cnt <= '0;
                    pass_cnt <= pass_cnt + 2'd1;
                    if (lat_mem_gpr) begin
                        vgpr_wr_en   <= 1'b1;
                        vgpr_wr_addr <= lat_vgpr_base + {8'b0, pass_cnt};
                        vgpr_wr_data <= acc_merged;
                        vgpr_wr_mask <= lat_exec_mask;
                    end else begin
                        sgpr_wr_en   <= 1'b1;
                        sgpr_wr_addr <= lat_sgpr_base + {5'b0, pass_cnt, 2'b00};
                        sgpr_wr_data <= acc_merged[127:0];
                        sgpr_wr_mask <= lat_sgpr_mask;
                    end
                    if (op_end) begin
                        wb_done      <= 1'b1;
                        wb_done_wfid <= lat_wfid;
                    end
                end else begin
                    acc      <= acc_merged;
                    beat_cnt <= beat_cnt + 6'd1;
                end
            end
        end
    end

endmodule
